sysarr_sparse_encoder: RTL and testbench
========================================

SYSARR_SPARSE_ENCODER -- requirements
Module: sysarr_sparse_encoder

Interface
REQ-001 The block SHALL have parameter N, default 4: elements per input vector.
REQ-002 The block SHALL have parameter DATA_W, default 16: bits per element.
REQ-003 The block SHALL have parameter IND_W, default 2: index width, equal to clog2(N).
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port nRST, input, 1: synchronous, active-low reset, sampled on rising clk.
REQ-006 Port in_valid, input, 1: in_vec holds a valid dense vector.
REQ-007 Port in_vec, input, N*DATA_W: dense vector; element i occupies bits [i*DATA_W +: DATA_W].
REQ-008 Port in_ready, output, 1: block can accept a vector.
REQ-009 Port fifo_full, input, 1: downstream sysarr_FIFO cannot accept a load.
REQ-010 Port load, output, 1: one-cycle write strobe to the downstream FIFO.
REQ-011 Port load_vals, output, DATA_W: value written when load=1.
REQ-012 Port load_inds, output, IND_W: element index of load_vals within the vector.
REQ-013 Port done, output, 1: one-cycle pulse marking end of vector.
REQ-014 Port nnz_count, output, IND_W+1: number of loads issued for the last vector.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, in_valid=1 SHALL capture in_vec into an internal register, clear ptr and the nnz counter, and move to SCAN on the next edge.
REQ-018 In SCAN, cur SHALL be captured element[ptr]; load SHALL be 1 combinationally when cur!=0 and fifo_full=0, with load_vals=cur and load_inds=ptr.
REQ-019 In SCAN, if cur!=0 and fifo_full=1, ptr SHALL hold and the FSM SHALL stall.
REQ-020 In SCAN, a zero element SHALL advance ptr with load=0.
REQ-021 An issued load SHALL increment the nnz counter and advance ptr.
REQ-022 When ptr=N-1 advances, the FSM SHALL move to DONE instead of wrapping ptr.
REQ-023 DONE SHALL last one cycle with done=1 and nnz_count valid, then return to IDLE.
REQ-024 nnz_count SHALL hold its value until the next DONE.
REQ-025 Timing without stalls: accept at cycle T, element i evaluated at T+1+i, done at T+1+N, in_ready high again at T+2+N.
REQ-026 An all-zero vector SHALL spend N cycles in SCAN with no loads, then assert done with nnz_count=0.
REQ-027 fifo_full asserted on a zero element SHALL have no effect.
REQ-028 load_vals and load_inds SHALL be 0 whenever load=0.
REQ-029 in_valid outside IDLE SHALL be ignored; the in_vec register SHALL not change.

Reset
REQ-030 nRST=0 at a rising edge SHALL force IDLE, ptr=0, nnz counter=0, nnz_count=0 and clear the vector register.
REQ-031 During reset and the following IDLE: load=0, done=0, in_ready=1 once nRST=1.
REQ-032 Reset asserted mid-SCAN SHALL abandon the vector with no further loads and no done pulse.

Configuration
REQ-033 Macro SYSARR_ENC_ZERO_SKIP_EN defined: zero elements SHALL be skipped as specified above.
REQ-034 Macro SYSARR_ENC_ZERO_SKIP_EN undefined: every element SHALL be loaded, zeros included (dense mode); fifo_full SHALL stall every element; nnz_count SHALL equal N on completion.

Verification
REQ-035 Scenario, skip on: vector {0x0123, 0x0000, 0x89AB, 0x0000} with fifo_full=0 -> loads (0x0123, 0) at T+1 and (0x89AB, 2) at T+3, done at T+5, nnz_count=2.
REQ-036 Scenario, skip on: vector {0x0123, 0x4567, 0x89AB, 0xCDEF} with fifo_full=1 for 3 cycles from T+2 -> (0x4567, 1) issued at T+5, done at T+8, nnz_count=4, no duplicate loads.
REQ-037 Scenario: all-zero vector -> no load, done at T+5, nnz_count=0, in_ready=1 at T+6.
REQ-038 Scenario: nRST=0 at T+2 during a 4-nonzero vector -> only index 0 loaded, no done, in_ready=1 and nnz_count=0 after reset.
REQ-039 Scenario, skip off: vector {0x0000, 0x0001, 0x0000, 0x0002} -> four loads at indices 0-3 with values 0, 1, 0, 2, nnz_count=4.
REQ-040 Scenario: in_valid held high throughout -> vectors accepted only in IDLE, one per N+2 cycles; the vector register stays unchanged during SCAN and DONE.

Source files
------------

// File: rtl/sysarr_sparse_encoder.sv
// Sparse encoder: scans a captured dense vector and streams its elements into a downstream FIFO.
// Define SYSARR_ENC_ZERO_SKIP_EN to skip zero elements; left undefined, every element is loaded (dense mode).
module sysarr_sparse_encoder #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int IND_W  = 2
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                in_valid,
  input  logic [N*DATA_W-1:0] in_vec,
  output logic                in_ready,
  input  logic                fifo_full,
  output logic                load,
  output logic [DATA_W-1:0]   load_vals,
  output logic [IND_W-1:0]    load_inds,
  output logic                done,
  output logic [IND_W:0]      nnz_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [IND_W-1:0]    ptr_r;
  logic [IND_W:0]      cnt_r;
  logic [IND_W:0]      cnt_nxt_s;
  logic [IND_W:0]      nnz_count_r;
  logic [N*DATA_W-1:0] vec_r;
  logic [DATA_W-1:0]   cur_s;
  logic                scan_s;
  logic                live_s;
  logic                load_s;
  logic                advance_s;
  logic                last_s;

  function automatic logic [DATA_W-1:0] elem_at(input logic [N*DATA_W-1:0] vec,
                                                input logic [IND_W-1:0] idx);
    elem_at = vec[int'(idx)*DATA_W +: DATA_W];
  endfunction

  assign cur_s  = elem_at(vec_r, ptr_r);
  // Outputs are gated by nRST so a reset cycle mid-scan can never emit a load or done.
  assign scan_s = (state_r == SCAN) && nRST;

`ifdef SYSARR_ENC_ZERO_SKIP_EN
  assign live_s = (cur_s != {DATA_W{1'b0}});
`else
  assign live_s = 1'b1;
`endif

  assign load_s    = scan_s && live_s && !fifo_full;
  assign advance_s = scan_s && (load_s || !live_s);
  assign last_s    = (ptr_r == IND_W'(N - 1));
  assign cnt_nxt_s = cnt_r + {{IND_W{1'b0}}, load_s};

  // Next-state selection for the IDLE/SCAN/DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = SCAN;
        else          state_nxt_s = IDLE;
      end
      SCAN: begin
        if (advance_s && last_s) state_nxt_s = DONE;
        else                     state_nxt_s = SCAN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output drive; value and index read as zero whenever no load is issued.
  always_comb begin
    load      = load_s;
    in_ready  = (state_r == IDLE) && nRST;
    done      = (state_r == DONE) && nRST;
    nnz_count = nnz_count_r;
    if (load_s) begin
      load_vals = cur_s;
      load_inds = ptr_r;
    end else begin
      load_vals = {DATA_W{1'b0}};
      load_inds = {IND_W{1'b0}};
    end
  end

  // State, pointer, counters and the captured vector.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_r     <= IDLE;
      ptr_r       <= {IND_W{1'b0}};
      cnt_r       <= {(IND_W+1){1'b0}};
      nnz_count_r <= {(IND_W+1){1'b0}};
      vec_r       <= {(N*DATA_W){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            vec_r <= in_vec;
            ptr_r <= {IND_W{1'b0}};
            cnt_r <= {(IND_W+1){1'b0}};
          end
        end
        SCAN: begin
          if (advance_s) begin
            cnt_r <= cnt_nxt_s;
            // The final element publishes the count in the same edge that enters DONE.
            if (last_s) nnz_count_r <= cnt_nxt_s;
            else        ptr_r       <= ptr_r + IND_W'(1);
          end
        end
        DONE:    ptr_r <= {IND_W{1'b0}};
        default: ptr_r <= {IND_W{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_sysarr_sparse_encoder.sv
// Bench for sysarr_sparse_encoder: per-cycle queue model plus directed scenarios with literal expectations.
module tb_sysarr_sparse_encoder;

  logic        tb_clk = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic [63:0] in_vec;
  logic        in_ready;
  logic        fifo_full;
  logic        load;
  logic [15:0] load_vals;
  logic [1:0]  load_inds;
  logic        done;
  logic [2:0]  nnz_count;

  sysarr_sparse_encoder dut (
    .clk(tb_clk), .nRST(nRST), .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready), .fifo_full(fifo_full), .load(load),
    .load_vals(load_vals), .load_inds(load_inds), .done(done),
    .nnz_count(nnz_count)
  );

  always #5 tb_clk = ~tb_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: pending elements of the accepted vector, consumed one per cycle unless stalled.
  typedef struct { logic [15:0] v; int i; } el_t;
  el_t q[$];
  bit  done_due = 1'b0;
  int  m_cnt = 0;
  int  exp_nnz = 0;
  bit  e_load, e_done, e_rdy, live;
  logic [15:0] e_val;
  int  e_idx;

  int ld_cyc[$];
  int ld_val[$];
  int ld_idx[$];
  int done_q[$];
  int acc_q[$];
  int rdy_q[$];
  int t_acc;

  always @(negedge tb_clk) begin
    if (chk_en) begin
      if (load) begin
        ld_cyc.push_back(cyc); ld_val.push_back(int'(load_vals)); ld_idx.push_back(int'(load_inds));
      end
      if (done) done_q.push_back(cyc);
      if (in_ready && nRST) rdy_q.push_back(cyc);
      if (in_ready && in_valid && nRST) acc_q.push_back(cyc);
      if (!nRST) begin
        check("rst_load", load, 0);
        check("rst_done", done, 0);
        q.delete();
        done_due = 1'b0;
        exp_nnz = 0;
      end else begin
        e_load = 0; e_done = 0; e_rdy = 0; e_val = 16'h0; e_idx = 0;
        if (done_due) begin
          e_done = 1;
          exp_nnz = m_cnt;
          done_due = 1'b0;
        end else if (q.size() > 0) begin
`ifdef SYSARR_ENC_ZERO_SKIP_EN
          live = (q[0].v != 16'h0);
`else
          live = 1'b1;
`endif
          if (live && !fifo_full) begin
            e_load = 1; e_val = q[0].v; e_idx = q[0].i;
            m_cnt++;
            void'(q.pop_front());
          end else if (!live) begin
            void'(q.pop_front());
          end
          if (q.size() == 0) done_due = 1'b1;
        end else begin
          e_rdy = 1;
          if (in_valid) begin
            for (int i = 0; i < 4; i++) q.push_back('{in_vec[i*16 +: 16], i});
            m_cnt = 0;
          end
        end
        check("load", load, e_load);
        check("load_vals", load_vals, e_val);
        check("load_inds", load_inds, e_idx);
        check("done", done, e_done);
        check("in_ready", in_ready, e_rdy);
        check("nnz_count", nnz_count, exp_nnz);
      end
    end
  end

  function automatic logic [63:0] pat(input int k);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'hA000 | 16'(k << 4) | 16'(i);
    return r;
  endfunction

  // Drives one vector at cycle T, then fifo_full / nRST relative to T for ncyc cycles.
  task automatic run_vec(input logic [63:0] v, input int fs, input int fl, input int rst_at,
                         input bit hold, input int ncyc);
    ld_cyc.delete(); ld_val.delete(); ld_idx.delete();
    done_q.delete(); acc_q.delete(); rdy_q.delete();
    @(posedge tb_clk); #1;
    t_acc = cyc; in_valid = 1'b1; in_vec = hold ? pat(0) : v;
    for (int k = 1; k < ncyc; k++) begin
      @(posedge tb_clk); #1;
      in_valid  = hold && (k < 13);
      in_vec    = hold ? pat(k) : v;
      fifo_full = (k >= fs) && (k < fs + fl);
      nRST      = (k != rst_at);
    end
    in_valid = 1'b0; fifo_full = 1'b0; nRST = 1'b1;
  endtask

  task automatic exp_load(input string nm, input int k, input int off, input int val, input int idx);
    check({nm, "_count"}, (ld_cyc.size() > k), 1);
    if (ld_cyc.size() > k) begin
      check({nm, "_t"}, ld_cyc[k] - t_acc, off);
      check({nm, "_v"}, ld_val[k], val);
      check({nm, "_i"}, ld_idx[k], idx);
    end
  endtask

  task automatic exp_done(input string nm, input int nloads, input int off, input int nnz);
    check({nm, "_nloads"}, ld_cyc.size(), nloads);
    check({nm, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0) check({nm, "_done_t"}, done_q[0] - t_acc, off);
    check({nm, "_nnz"}, nnz_count, nnz);
  endtask

  function automatic int first_rdy_after(input int t);
    foreach (rdy_q[j]) if (rdy_q[j] > t) return rdy_q[j];
    return -1;
  endfunction

  initial begin
    nRST = 1'b0; in_valid = 1'b0; in_vec = 64'h0; fifo_full = 1'b0;
    repeat (3) @(posedge tb_clk);
    #1 chk_en = 1'b1;
    @(posedge tb_clk); #1 nRST = 1'b1;
    @(posedge tb_clk); #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_load", load, 0);
    check("reset_done", done, 0);
    check("reset_nnz", nnz_count, 0);

    // Two nonzeros with zeros between, no back-pressure.
    run_vec({16'h0000, 16'h89AB, 16'h0000, 16'h0123}, 99, 0, -1, 1'b0, 10);
`ifdef SYSARR_ENC_ZERO_SKIP_EN
    exp_load("a0", 0, 1, 16'h0123, 0);
    exp_load("a1", 1, 3, 16'h89AB, 2);
    exp_done("a", 2, 5, 2);
`else
    exp_load("a0", 0, 1, 16'h0123, 0);
    exp_load("a1", 1, 2, 16'h0000, 1);
    exp_load("a2", 2, 3, 16'h89AB, 2);
    exp_load("a3", 3, 4, 16'h0000, 3);
    exp_done("a", 4, 5, 4);
`endif

    // All nonzero, FIFO full for three cycles on element 1.
    run_vec({16'hCDEF, 16'h89AB, 16'h4567, 16'h0123}, 2, 3, -1, 1'b0, 12);
    exp_load("b0", 0, 1, 16'h0123, 0);
    exp_load("b1", 1, 5, 16'h4567, 1);
    exp_load("b2", 2, 6, 16'h89AB, 2);
    exp_load("b3", 3, 7, 16'hCDEF, 3);
    exp_done("b", 4, 8, 4);

    // All-zero vector.
    run_vec(64'h0, 99, 0, -1, 1'b0, 10);
`ifdef SYSARR_ENC_ZERO_SKIP_EN
    exp_done("z", 0, 5, 0);
`else
    exp_load("z3", 3, 4, 16'h0000, 3);
    exp_done("z", 4, 5, 4);
`endif
    check("z_ready_t", first_rdy_after(t_acc) - t_acc, 6);

    // FIFO full while a zero element is under evaluation.
    run_vec({16'h0000, 16'h89AB, 16'h0000, 16'h0123}, 2, 1, -1, 1'b0, 10);
`ifdef SYSARR_ENC_ZERO_SKIP_EN
    exp_load("f1", 1, 3, 16'h89AB, 2);
    exp_done("f", 2, 5, 2);
`else
    exp_load("f1", 1, 3, 16'h0000, 1);
    exp_load("f3", 3, 5, 16'h0000, 3);
    exp_done("f", 4, 6, 4);
`endif

    // Sparse small values.
    run_vec({16'h0002, 16'h0000, 16'h0001, 16'h0000}, 99, 0, -1, 1'b0, 10);
`ifdef SYSARR_ENC_ZERO_SKIP_EN
    exp_load("c0", 0, 2, 16'h0001, 1);
    exp_load("c1", 1, 4, 16'h0002, 3);
    exp_done("c", 2, 5, 2);
`else
    exp_load("c0", 0, 1, 16'h0000, 0);
    exp_load("c1", 1, 2, 16'h0001, 1);
    exp_load("c2", 2, 3, 16'h0000, 2);
    exp_load("c3", 3, 4, 16'h0002, 3);
    exp_done("c", 4, 5, 4);
`endif

    // Reset at T+2 abandons the vector.
    run_vec({16'hCDEF, 16'h89AB, 16'h4567, 16'h0123}, 99, 0, 2, 1'b0, 10);
    exp_load("r0", 0, 1, 16'h0123, 0);
    check("r_nloads", ld_cyc.size(), 1);
    check("r_ndone", done_q.size(), 0);
    check("r_nnz", nnz_count, 0);
    check("r_in_ready", in_ready, 1);

    // in_valid held high with in_vec changing every cycle.
    run_vec(64'h0, 99, 0, -1, 1'b1, 20);
    check("h_nacc", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("h_acc1", acc_q[1] - t_acc, 6);
      check("h_acc2", acc_q[2] - t_acc, 12);
    end
    exp_load("h0", 0, 1, 16'hA000, 0);
    exp_load("h3", 3, 4, 16'hA003, 3);
    exp_load("h4", 4, 7, 16'hA060, 0);
    exp_load("h8", 8, 13, 16'hA0C0, 0);
    check("h_ndone", done_q.size(), 3);

    repeat (2) @(posedge tb_clk);
    #1 chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
